// File: rtl/uart_tx_fifo_reader_if.sv
// rtl/uart_tx_fifo_reader_if.sv - read-port bundle between the io_hub TX FIFO and its UART reader
// master = reader (drives the pop strobe), slave = FIFO.
interface uart_tx_fifo_reader_if #(
   parameter int SIZE = 8
);
   logic            fifo_empty;
   logic [SIZE-1:0] fifo_dout;
   logic            fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_dout,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_dout,
      input  fifo_rd_en
   );
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - pops the io_hub TX FIFO and serializes each byte as 8N1 UART, LSB first
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo_reader #(
   parameter int CLK_DIV = 16,
   parameter int SIZE    = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_tx_enable,
   uart_tx_fifo_reader_if.master fifo,
   output logic                  o_tx,
   output logic                  o_busy
);
   localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   logic [2:0]       r_state;
   logic [15:0]      r_baud_cnt;
   logic [IDX_W-1:0] r_bit_idx;
   logic [SIZE-1:0]  r_shift;
   logic             r_rd_en;
   logic             r_tx;
   logic             r_busy;
`ifdef UART_TX_PARITY_EN
   logic             r_parity;
`endif

   logic w_bit_end;
   logic w_start;
   logic w_last_bit;

   assign w_bit_end  = (r_baud_cnt == 16'(CLK_DIV - 1));
   assign w_start    = i_tx_enable && !fifo.fifo_empty;
   assign w_last_bit = (r_bit_idx == IDX_W'(SIZE - 1));

   // tx is assigned from the current state, so the line trails each state change by one cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_rd_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
      end else begin
         r_rd_en <= 1'b0;

         if (r_state == S_IDLE || r_state == S_FETCH) begin
            r_baud_cnt <= '0;
         end else if (w_bit_end) begin
            r_baud_cnt <= '0;
         end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
         end

         case (r_state)
            S_IDLE: begin
               r_tx      <= 1'b1;
               r_bit_idx <= '0;
               r_busy    <= w_start;
               if (w_start) begin
                  r_rd_en <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_tx    <= 1'b1;
               r_shift <= fifo.fifo_dout;
`ifdef UART_TX_PARITY_EN
               r_parity <= ^fifo.fifo_dout;
`endif
               r_state <= S_START;
            end
            S_START: begin
               r_tx <= 1'b0;
               if (w_bit_end) begin
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               r_tx <= r_shift[r_bit_idx];
               if (w_bit_end) begin
                  if (w_last_bit) begin
                     r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     r_state   <= S_PARITY;
`else
                     r_state   <= S_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               r_tx <= r_parity;
               if (w_bit_end) begin
                  r_state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               r_tx <= 1'b1;
               if (w_bit_end) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign fifo.fifo_rd_en = r_rd_en;
   assign o_tx            = r_tx;
   assign o_busy          = r_busy;
endmodule
